rpsc_card10_status_reader: RTL and testbench

Reads back the latch state of the RPSC card-10 flip-flop group. Inputs are the eight LA outputs (FF25..FF32) and the two EP1 outputs (EP1_39, EP1_40).
It synchronises and debounces the ten lines and holds a stable snapshot. On every change, or on a periodic heartbeat, it sends a 3-byte status frame over a valid/ready byte stream to the host-link transmitter.

---
 rtl/rpsc_pkg.sv | 45 ++++
 rtl/rpsc_debounce.sv | 52 +++++
 rtl/rpsc_card10_status_reader.sv | 161 ++++++++++++++++
 tb/tb_rpsc_card10_status_reader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpsc_pkg.sv
// ----------------------------------------------------------------------------
// rpsc_pkg: shared types and constants for the RPSC card-10 status reader. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rpsc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_B1   = 2'd2,
    ST_B2   = 2'd3
  } state_t;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  typedef struct packed {
    logic [1:0] ep;
    logic [7:0] la;
  } status_t;

  localparam int STATUS_W = $bits(status_t);

  localparam int LA_FF25_BIT = 0;
  localparam int LA_FF26_BIT = 1;
  localparam int LA_FF27_BIT = 2;
  localparam int LA_FF28_BIT = 3;
  localparam int LA_FF29_BIT = 4;
  localparam int LA_FF30_BIT = 5;
  localparam int LA_FF31_BIT = 6;
  localparam int LA_FF32_BIT = 7;
  localparam int EP1_39_BIT  = 0;
  localparam int EP1_40_BIT  = 1;

  // Last frame byte; the parity bit makes the 16 payload bits odd parity.
  function automatic logic [7:0] status_byte2(input status_t s, input logic reason,
                                              input logic [3:0] seq);
    logic par;
    par = ~^{s.la, s.ep, reason, seq};
    return {s.ep, reason, seq, par};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rpsc_debounce.sv
// ----------------------------------------------------------------------------
// rpsc_debounce: 2-flop synchroniser plus whole-vector debounce with change pulse. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rpsc_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic             change_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1        <= '0;
      sync2        <= '0;
      cand         <= '0;
      cnt          <= '0;
      stable       <= '0;
      change_pulse <= 1'b0;
    end else begin
      sync1        <= din;
      sync2        <= sync1;
      change_pulse <= 1'b0;
      // Any difference from the candidate restarts the settling count.
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end else if (cand != stable) begin
        stable       <= cand;
        change_pulse <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rpsc_card10_status_reader.sv
// ----------------------------------------------------------------------------
// rpsc_card10_status_reader: debounced card-10 latch snapshot sent as 3-byte frames. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rpsc_card10_status_reader
  import rpsc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int HEARTBEAT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] la_in,
  input  logic [1:0] ep_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] la_stable,
  output logic [1:0] ep_stable,
  output logic       change_pulse
);

  status_t              raw;
  status_t              stable_s;
  logic [STATUS_W-1:0]  stable_vec;
  status_t              snap;
  state_t               state;
  logic                 reason;
  logic [3:0]           seq;
  logic                 pending;
  logic                 hb_trig;
  logic                 handshake;
  logic                 frame_start;

  always_comb begin
    raw = '0;
    raw.la[LA_FF25_BIT] = la_in[0];
    raw.la[LA_FF26_BIT] = la_in[1];
    raw.la[LA_FF27_BIT] = la_in[2];
    raw.la[LA_FF28_BIT] = la_in[3];
    raw.la[LA_FF29_BIT] = la_in[4];
    raw.la[LA_FF30_BIT] = la_in[5];
    raw.la[LA_FF31_BIT] = la_in[6];
    raw.la[LA_FF32_BIT] = la_in[7];
    raw.ep[EP1_39_BIT]  = ep_in[0];
    raw.ep[EP1_40_BIT]  = ep_in[1];
  end

  rpsc_debounce #(
    .WIDTH           (STATUS_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk          (clk),
    .rst_n        (reset),
    .din          (raw),
    .stable       (stable_vec),
    .change_pulse (change_pulse)
  );

  assign stable_s  = stable_vec;
  assign la_stable = stable_s.la;
  assign ep_stable = stable_s.ep;

  assign handshake   = tx_valid && tx_ready;
  assign frame_start = (state == ST_IDLE) && (change_pulse || hb_trig);

  generate
    if (HEARTBEAT_CYCLES > 0) begin : g_hb_on
      localparam int HB_W = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
      localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

      logic [HB_W-1:0] hb_cnt;
      logic            hb_trig_r;

      // Counts idle cycles only; the trigger is registered so it lands one cycle later.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          hb_cnt    <= '0;
          hb_trig_r <= 1'b0;
        end else begin
          hb_trig_r <= 1'b0;
          if (frame_start) begin
            hb_cnt <= '0;
          end else if (state == ST_IDLE) begin
            if (hb_cnt == HB_LAST) begin
              hb_cnt    <= '0;
              hb_trig_r <= 1'b1;
            end else begin
              hb_cnt <= hb_cnt + 1'b1;
            end
          end
        end
      end

      assign hb_trig = hb_trig_r;
    end else begin : g_hb_off
      assign hb_trig = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      snap     <= '0;
      reason   <= 1'b0;
      seq      <= 4'd0;
      pending  <= 1'b0;
    end else begin
      if ((state != ST_IDLE) && change_pulse) begin
        pending <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            snap     <= stable_s;
            reason   <= change_pulse;
            state    <= ST_HDR;
            tx_valid <= 1'b1;
            tx_data  <= FRAME_HDR;
          end
        end
        ST_HDR: begin
          if (handshake) begin
            state   <= ST_B1;
            tx_data <= snap.la;
          end
        end
        ST_B1: begin
          if (handshake) begin
            state   <= ST_B2;
            tx_data <= status_byte2(snap, reason, seq);
          end
        end
        ST_B2: begin
          if (handshake) begin
            seq <= seq + 4'd1;
            // A change seen during this frame (even on this very cycle) chains a follow-up.
            if (pending || change_pulse) begin
              pending <= 1'b0;
              snap    <= stable_s;
              reason  <= 1'b1;
              state   <= ST_HDR;
              tx_data <= FRAME_HDR;
            end else begin
              state    <= ST_IDLE;
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rpsc_card10_status_reader.sv
// ----------------------------------------------------------------------------
// tb_rpsc_card10_status_reader: randomized scoreboard bench for the card-10 status reader. Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rpsc_card10_status_reader;

  localparam int D  = 16;
  localparam int HB = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, reset_hb;
  logic [7:0] la_in;
  logic [1:0] ep_in;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [7:0] la_stable;
  logic [1:0] ep_stable;
  logic       change_pulse;

  logic [7:0] hb_la_in;
  logic [1:0] hb_ep_in;
  logic       hb_ready;
  logic [7:0] hb_data;
  logic       hb_valid;
  logic [7:0] hb_la_stable;
  logic [1:0] hb_ep_stable;
  logic       hb_change_pulse;

  rpsc_card10_status_reader #(.DEBOUNCE_CYCLES(D), .HEARTBEAT_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .la_in(la_in), .ep_in(ep_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .la_stable(la_stable), .ep_stable(ep_stable), .change_pulse(change_pulse)
  );

  rpsc_card10_status_reader #(.DEBOUNCE_CYCLES(D), .HEARTBEAT_CYCLES(HB)) dut_hb (
    .clk(clk), .reset(reset_hb), .la_in(hb_la_in), .ep_in(hb_ep_in),
    .tx_data(hb_data), .tx_valid(hb_valid), .tx_ready(hb_ready),
    .la_stable(hb_la_stable), .ep_stable(hb_ep_stable), .change_pulse(hb_change_pulse)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [3:0] model_seq = 4'd0;
  logic [9:0] model_stable = 10'd0;
  int         exp_pulses = 0;
  int         seen_pulses = 0;
  logic       rnd_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic odd_par(input logic [14:0] bits);
    return ($countones(bits) % 2) == 0;
  endfunction

  // Expected frame: header, LA snapshot, then {ep, reason, seq, parity}.
  task automatic push_frame(input logic [7:0] la, input logic [1:0] ep, input logic reason);
    exp_q.push_back(8'hA5);
    exp_q.push_back(la);
    exp_q.push_back({ep, reason, model_seq, odd_par({la, ep, reason, model_seq})});
    model_seq = model_seq + 4'd1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_ready) tx_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_valid(input int lim);
    int n = 0;
    while (!tx_valid && n < lim) begin
      tick(1);
      n++;
    end
    check("valid_timeout", {31'd0, tx_valid}, 32'd1);
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < lim) begin
      tick(1);
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  // Monitor for the main instance: stall stability and scoreboard pops.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset) begin
      if (change_pulse) seen_pulses++;
      if (prev_stall) begin
        check("hold_valid", {31'd0, tx_valid}, 32'd1);
        check("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h expected none", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("frame_byte", {24'd0, tx_data}, {24'd0, e});
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Monitor for the heartbeat instance: period, content and sequence wrap.
  int         cyc = 0;
  int         hb_idx = 0;
  int         hb_frames = 0;
  int         hb_last = 0;
  logic [3:0] hb_seq = 4'd0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (reset_hb && hb_valid && hb_ready) begin
      case (hb_idx)
        0: begin
          check("hb_hdr", {24'd0, hb_data}, 32'hA5);
          if (hb_frames > 0) check("hb_period", cyc - hb_last, HB + 4);
          hb_last = cyc;
        end
        1: check("hb_la", {24'd0, hb_data}, 32'd0);
        default: begin
          check("hb_b2", {24'd0, hb_data},
                {24'd0, 3'b000, hb_seq, odd_par({10'd0, 1'b0, hb_seq})});
          hb_seq = hb_seq + 4'd1;
          hb_frames++;
        end
      endcase
      hb_idx = (hb_idx + 1) % 3;
    end
  end

  initial begin
    logic [9:0] nv;
    logic       vseen;
    int         n;
    reset = 1'b0; reset_hb = 1'b0;
    la_in = 8'h00; ep_in = 2'b00; tx_ready = 1'b1;
    hb_la_in = 8'h00; hb_ep_in = 2'b00; hb_ready = 1'b1;

    tick(3);
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_stable", {22'd0, ep_stable, la_stable}, 32'd0);
    check("rst_pulse", {31'd0, change_pulse}, 32'd0);
    reset = 1'b1; reset_hb = 1'b1;
    tick(3);

    // Exact latency of the first change and back-to-back frame bytes.
    la_in = 8'h01;
    push_frame(8'h01, 2'b00, 1'b1);
    exp_pulses++;
    model_stable = 10'h001;
    for (int k = 0; k <= D + 6; k++) begin
      tick(1);
      if (k == D + 1) check("lat_before", {24'd0, la_stable}, 32'h00);
      if (k == D + 2) begin
        check("lat_stable", {24'd0, la_stable}, 32'h01);
        check("lat_pulse", {31'd0, change_pulse}, 32'd1);
        check("lat_novalid", {31'd0, tx_valid}, 32'd0);
      end
      if (k == D + 3) check("lat_valid", {23'd0, tx_valid, tx_data}, 32'h1A5);
      if (k == D + 5) check("frame_b2_valid", {31'd0, tx_valid}, 32'd1);
      if (k == D + 6) check("frame_end", {31'd0, tx_valid}, 32'd0);
    end

    // Short glitch on FF28 must be filtered out.
    la_in = 8'h09;
    tick(5);
    la_in = 8'h01;
    vseen = 1'b0;
    for (int k = 0; k < D + 6; k++) begin
      tick(1);
      vseen |= tx_valid;
    end
    check("glitch_stable", {24'd0, la_stable}, 32'h01);
    check("glitch_valid", {31'd0, vseen}, 32'd0);
    check("glitch_pulses", seen_pulses, exp_pulses);

    // Twenty-cycle stall in the header byte.
    tx_ready = 1'b0;
    la_in = 8'h5A;
    push_frame(8'h5A, 2'b00, 1'b1);
    exp_pulses++;
    model_stable = 10'h05A;
    wait_valid(D + 10);
    tick(20);
    check("stall_hdr", {23'd0, tx_valid, tx_data}, 32'h1A5);
    tx_ready = 1'b1;
    wait_drain(50);

    // Several changes inside one stalled frame collapse into one follow-up.
    tx_ready = 1'b0;
    la_in = 8'h01;
    push_frame(8'h01, 2'b00, 1'b1);
    wait_valid(D + 10);
    la_in = 8'h03;
    tick(D + 6);
    la_in = 8'h07;
    tick(D + 6);
    push_frame(8'h07, 2'b00, 1'b1);
    exp_pulses += 3;
    model_stable = 10'h007;
    tx_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check("chain_valid", {31'd0, tx_valid}, (i < 6) ? 32'd1 : 32'd0);
    end
    wait_drain(20);

    // Randomized changes and glitches with random back-pressure.
    rnd_ready = 1'b1;
    for (int it = 0; it < 24; it++) begin
      do nv = 10'($urandom); while (nv == model_stable);
      if ($urandom_range(0, 2) == 0) begin
        {ep_in, la_in} = nv;
        tick($urandom_range(1, D - 1));
        {ep_in, la_in} = model_stable;
        tick(D + 4);
      end else begin
        {ep_in, la_in} = nv;
        push_frame(nv[7:0], nv[9:8], 1'b1);
        exp_pulses++;
        model_stable = nv;
        tick(D + 3);
        wait_drain(300);
      end
      check("rand_stable", {22'd0, ep_stable, la_stable}, {22'd0, model_stable});
    end
    rnd_ready = 1'b0;
    tx_ready = 1'b1;
    tick(2);
    check("rand_pulses", seen_pulses, exp_pulses);

    // Reset in the middle of B1 while stalled.
    tx_ready = 1'b0;
    nv = model_stable ^ 10'h003;
    {ep_in, la_in} = nv;
    push_frame(nv[7:0], nv[9:8], 1'b1);
    wait_valid(D + 10);
    tx_ready = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b0;
    #2 reset = 1'b0;
    la_in = 8'h00; ep_in = 2'b00;
    #1;
    check("arst_valid", {31'd0, tx_valid}, 32'd0);
    check("arst_data", {24'd0, tx_data}, 32'd0);
    check("arst_stable", {22'd0, ep_stable, la_stable}, 32'd0);
    check("arst_pulse", {31'd0, change_pulse}, 32'd0);
    exp_q.delete();
    model_seq = 4'd0;
    model_stable = 10'd0;
    tick(3);
    reset = 1'b1;
    tx_ready = 1'b1;
    vseen = 1'b0;
    for (int k = 0; k < 3 * D; k++) begin
      tick(1);
      vseen |= tx_valid;
    end
    check("post_rst_quiet", {31'd0, vseen}, 32'd0);
    la_in = 8'h81;
    push_frame(8'h81, 2'b00, 1'b1);
    model_stable = 10'h081;
    wait_valid(D + 10);
    wait_drain(20);
    check("post_rst_stable", {24'd0, la_stable}, 32'h81);

    // Let the heartbeat instance run past a sequence wrap.
    n = 0;
    while (hb_frames < 18 && n < 5000) begin
      tick(1);
      n++;
    end
    check("hb_frames", {31'd0, hb_frames >= 18}, 32'd1);
    check("final_queue", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
